fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Fetch-side counterpart of the branch comparator. It consumes PCSrc and the jump and target signals, owns the PC register, and fetches instructions from instruction memory over a valid/ready request and valid response interface.
- It presents one instruction at a time to decode/execute with a valid/ready handshake, so the core tolerates multi-cycle instruction memory.
- The next PC is chosen when the presented instruction retires: the target if a redirect is asserted, otherwise PC+4.
- One outstanding request at most.

Parameters:
- N, 32: address/data width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- PCSrc  input  1  branch taken (comparator output, already ANDed with Branch); sampled only at retire.
- Jump  input  1  unconditional redirect (JAL/JALR); sampled only at retire.
- target  input  N  redirect address; sampled only at retire.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  N  fetch address; always equals pc.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  N  fetched instruction word.
- instr_valid  output  1  instr and instr_pc are valid.
- instr_ready  input  1  downstream retires the presented instruction this cycle.
- instr  output  N  buffered instruction.
- instr_pc  output  N  address of the buffered instruction.
- fetch_err  output  1  sticky misaligned-redirect flag.

Behaviour:
- Reset, asynchronous and at any time, including mid-request:
  - pc = RESET_PC, state = S_REQ.
  - instr_valid = 0, instr = 0, instr_pc = 0, fetch_err = 0.
  - imem_req_valid follows the state, so it is 1 right after reset.
  - Any in-flight memory response is dropped, because state leaves S_WAIT.
- FSM states: S_REQ, S_WAIT, S_HOLD, S_ERR.
- S_REQ:
  - Outputs: imem_req_valid = 1, imem_addr = pc.
  - If imem_req_ready: go to S_WAIT. Otherwise stay; the request stays stable until accepted.
- S_WAIT:
  - imem_req_valid = 0.
  - rsp_valid is ignored in every other state.
  - If imem_rsp_valid: instr <= imem_rsp_data, instr_pc <= pc, go to S_HOLD.
- S_HOLD:
  - instr_valid = 1; instr and instr_pc are held stable.
  - If instr_ready:
    - Redirect case: redir = PCSrc | Jump. If redir, the new pc is target; otherwise it is pc + 4, with 32-bit wrap (pc 32'hFFFF_FFFC becomes 32'h0).
    - If redir and target[1:0] != 2'b00: fetch_err <= 1, pc unchanged, go to S_ERR.
    - Otherwise: pc <= new pc, go to S_REQ.
  - If instr_ready is low, PCSrc, Jump and target are ignored.
- S_ERR:
  - All handshake outputs are 0 and instr_valid = 0.
  - fetch_err = 1.
  - Only reset exits this state.
- Outputs:
  - instr_valid = (state == S_HOLD).
  - imem_req_valid = (state == S_REQ).
  - All outputs are Moore; there is no combinational path from any input to any output.
- Latency:
  - Best case is 3 cycles per instruction: REQ accepted, response the next cycle, retire in HOLD.
  - First imem_req_valid is in the first cycle after reset deassertion.
- Simultaneous PCSrc and Jump: both mean redirect to target; no priority is needed.
- imem_rsp_valid in the same cycle as request acceptance belongs to the previous state and is ignored. Memory must respond no earlier than the cycle after acceptance.

Decomposition:
- Add to the shared defs package:
  - fetch_state_t enum (S_REQ, S_WAIT, S_HOLD, S_ERR).
  - INSTR_BYTES = 4.
  - RESET_PC_DEFAULT.
- Sub-module pc_next (combinational): inputs pc, target, PCSrc, Jump; outputs next_pc and misalign. It is reusable by a later pipelined fetch.
- The FSM, PC register and instruction buffer stay in fetch_unit.

Test Plan:
- Sequential fetch: reset, imem ready every cycle, rsp one cycle after accept, instr_ready=1, no redirect. Expect imem_addr sequence 0x0, 0x4, 0x8 at 3-cycle spacing; instr_pc matches each address.
- Backpressure and hold:
  - Hold imem_req_ready=0 for 5 cycles: imem_addr stays 0x4 and imem_req_valid stays 1.
  - Then hold instr_ready=0 for 4 cycles in HOLD, toggling PCSrc and target=0x100 meanwhile: instr stays stable and the next fetch is still pc+4.
- Branch taken: at retire of instr_pc=0x8 with PCSrc=1, target=0x40, expect next imem_addr=0x40. With Jump=1 and PCSrc=1 together, target=0x80, expect 0x80.
- Misaligned redirect: at retire, Jump=1, target=0x42. Expect fetch_err=1 next cycle, no further imem_req_valid, state held until reset, then pc=RESET_PC and fetch_err=0.
- Reset mid-request: assert reset in S_WAIT with rsp_valid arriving the same cycle. Expect instr_valid=0 and that data not captured; after deassert, first request at RESET_PC.
- Wrap: RESET_PC=32'hFFFF_FFFC, retire with no redirect. Expect next imem_addr=0x0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-side definitions: FSM states, instruction size, reset PC.
// Imported by fetch_unit and pc_next.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: target on redirect, else pc + 4 (wraps).
// Ports: pc, target, PCSrc, Jump in; next_pc, misalign out.
module pc_next
  import fetch_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] pc,
  input  logic [N-1:0] target,
  input  logic         PCSrc,
  input  logic         Jump,
  output logic [N-1:0] next_pc,
  output logic         misalign
);

  logic redir;

  assign redir    = PCSrc | Jump;
  assign next_pc  = redir ? target : pc + N'(INSTR_BYTES);
  assign misalign = redir & (target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC register, one-outstanding imem request FSM, instr buffer.
// Ports: imem req/rsp, instr valid/ready to decode, redirect in, fetch_err.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc,
  input  logic         Jump,
  input  logic [N-1:0] target,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [N-1:0] imem_rsp_data,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  output logic         fetch_err
);

  fetch_state_t state, state_d;
  logic [N-1:0] pc;
  logic [N-1:0] npc;
  logic         misalign;
  logic         retire;
  logic         capture;

  pc_next #(.N(N)) u_pc_next (
    .pc       (pc),
    .target   (target),
    .PCSrc    (PCSrc),
    .Jump     (Jump),
    .next_pc  (npc),
    .misalign (misalign)
  );

  assign retire    = (state == S_HOLD) & instr_ready;
  assign capture   = (state == S_WAIT) & imem_rsp_valid;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_REQ;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_REQ:  if (imem_req_ready) state_d = S_WAIT;
      S_WAIT: if (imem_rsp_valid) state_d = S_HOLD;
      S_HOLD: if (instr_ready)
                state_d = misalign ? S_ERR : S_REQ;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    unique case (state)
      S_REQ:   imem_req_valid = 1'b1;
      S_HOLD:  instr_valid    = 1'b1;
      default: ;
    endcase
  end

  // A misaligned redirect leaves pc pointing at the faulting instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      instr     <= '0;
      instr_pc  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (capture) begin
        instr    <= imem_rsp_data;
        instr_pc <= pc;
      end
      if (retire) begin
        if (misalign) fetch_err <= 1'b1;
        else          pc        <= npc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// A second instance with RESET_PC=FFFF_FFFC exercises the pc wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc, Jump;
  logic [31:0] target;
  logic        imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_ready;

  logic        imem_req_valid, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr, instr_pc;

  logic        w_req_valid, w_instr_valid, w_fetch_err;
  logic [31:0] w_addr, w_instr, w_instr_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .PCSrc          (PCSrc),
    .Jump           (Jump),
    .target         (target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_err      (fetch_err)
  );

  fetch_unit #(.N(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .PCSrc          (PCSrc),
    .Jump           (Jump),
    .target         (target),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (w_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (w_instr_valid),
    .instr_ready    (instr_ready),
    .instr          (w_instr),
    .instr_pc       (w_instr_pc),
    .fetch_err      (w_fetch_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCSrc          = 1'b0;
    Jump           = 1'b0;
    target         = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
  endtask

  // One instruction: optional request stall, response, optional hold
  // stall with redirect noise, then retire with the given redirect.
  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] d,
                       input int          rs,
                       input int          hs,
                       input logic        ps,
                       input logic        jp,
                       input logic [31:0] tg);
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, a);
    for (int i = 0; i < rs; i++) begin
      imem_req_ready = 1'b0;
      step();
      chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_addr, a);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("wait_req", {31'd0, imem_req_valid}, 32'd0);
    chk("wait_ivalid", {31'd0, instr_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", instr, d);
    chk("hold_pc", instr_pc, a);
    for (int i = 0; i < hs; i++) begin
      instr_ready = 1'b0;
      PCSrc       = i[0];
      Jump        = ~i[0];
      target      = 32'h100;
      step();
      chk("stall_ivalid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, d);
      chk("stall_ipc", instr_pc, a);
    end
    PCSrc       = ps;
    Jump        = jp;
    target      = tg;
    instr_ready = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_reqv", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_addr", imem_addr, 32'd0);
    step();
    step();
    reset = 1'b0;

    // Sequential fetch, then backpressure on both sides.
    fetch(32'h0, 32'h1111_0013, 0, 0, 1'b0, 1'b0, 32'h0);
    fetch(32'h4, 32'h2222_0013, 5, 4, 1'b0, 1'b0, 32'h0);
    // Branch taken, then simultaneous PCSrc and Jump.
    fetch(32'h8, 32'h3333_0063, 0, 0, 1'b1, 1'b0, 32'h40);
    fetch(32'h40, 32'h4444_006F, 0, 0, 1'b1, 1'b1, 32'h80);
    // Misaligned jump target.
    fetch(32'h80, 32'h5555_006F, 0, 0, 1'b0, 1'b1, 32'h42);
    chk("err_flag", {31'd0, fetch_err}, 32'd1);
    chk("err_reqv", {31'd0, imem_req_valid}, 32'd0);
    chk("err_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("err_pc", imem_addr, 32'h80);
    for (int i = 0; i < 3; i++) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      instr_ready    = 1'b1;
      Jump           = 1'b1;
      target         = 32'h40;
      step();
      chk("err_stuck", {31'd0, fetch_err}, 32'd1);
      chk("err_noreq", {31'd0, imem_req_valid}, 32'd0);
    end
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("clr_err", {31'd0, fetch_err}, 32'd0);
    chk("clr_pc", imem_addr, 32'd0);
    step();
    reset = 1'b0;

    // Reset while waiting, with a response arriving at the same time.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("mid_wait", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    reset          = 1'b1;
    #1;
    chk("mid_reqv", {31'd0, imem_req_valid}, 32'd1);
    step();
    chk("mid_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("mid_instr", instr, 32'd0);
    reset = 1'b0;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    chk("mid_ivalid2", {31'd0, instr_valid}, 32'd0);
    fetch(32'h0, 32'h6666_0013, 0, 0, 1'b0, 1'b0, 32'h0);
    chk("mid_next", imem_addr, 32'h4);

    // Wrap at the top of the address space.
    reset = 1'b1;
    #1;
    chk("wrap_start", w_addr, 32'hFFFF_FFFC);
    step();
    reset = 1'b0;
    fetch(32'h0, 32'h7777_0013, 0, 0, 1'b0, 1'b0, 32'h0);
    chk("wrap_ipc", w_instr_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_reqv", {31'd0, w_req_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
